// File: rtl/alu_trace_pkg.sv
// rtl/alu_trace_pkg.sv - shared types and MISR taps for the ALU trace buffer
package alu_trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_HOLD    = 2'd2
    } trace_state_e;

    // One captured ALU operation at the default 16-bit width; rd_data uses this field order
    typedef struct packed {
        logic [1:0]  s;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] o;
    } trace_entry_t;

    // MISR feedback taps: three counted down from the MSB, one absolute low bit
    localparam int MISR_TAP_TOP_0 = 0;
    localparam int MISR_TAP_TOP_1 = 1;
    localparam int MISR_TAP_TOP_2 = 3;
    localparam int MISR_TAP_LOW   = 3;

endpackage

// File: rtl/trace_ram.sv
// rtl/trace_ram.sv - DEPTH x DW trace storage, one write port, registered read port
module trace_ram #(
    parameter int DEPTH = 8,
    parameter int DW    = 50
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DW-1:0]            wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DW-1:0]            rdata
);

    logic [DW-1:0] mem [DEPTH];

    // Array write; contents need no reset because count gates every read
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read; the output clears on reset and holds between reads
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/alu_trace_buffer.sv
// rtl/alu_trace_buffer.sv - circular ALU trace buffer; optional MISR via ALU_TRACE_MISR_EN
module alu_trace_buffer
    import alu_trace_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int W     = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cap_valid,
    input  logic [W-1:0]           cap_a,
    input  logic [W-1:0]           cap_b,
    input  logic [1:0]             cap_s,
    input  logic [W-1:0]           cap_o,
    input  logic                   arm,
    input  logic                   stop,
    input  logic                   wrap,
    input  logic                   rd_req,
    output logic                   rd_valid,
    output logic [3*W+1:0]         rd_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty,
    output logic                   overflow,
    output logic                   capturing,
    output logic [W-1:0]           sig
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    trace_state_e  state_q, state_d;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count_d;
    logic          wrap_q;
    logic          do_clear, do_write, do_read, do_overwrite;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and per-cycle actions; arm wins over rd_req in HOLD
    always_comb begin
        state_d      = state_q;
        count_d      = count;
        do_clear     = 1'b0;
        do_write     = 1'b0;
        do_read      = 1'b0;
        do_overwrite = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (arm) begin
                    do_clear = 1'b1;
                    count_d  = '0;
                    state_d  = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (cap_valid) begin
                    do_write = 1'b1;
                    if (count == FULL_COUNT) begin
                        do_overwrite = 1'b1;
                    end else begin
                        count_d = count + 1'b1;
                        if ((count == FULL_COUNT - 1'b1) && !wrap_q) begin
                            state_d = ST_HOLD;
                        end
                    end
                end
                if (stop) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (arm) begin
                    do_clear = 1'b1;
                    count_d  = '0;
                    state_d  = ST_CAPTURE;
                end else if (rd_req && !empty) begin
                    do_read = 1'b1;
                    count_d = count - 1'b1;
                    if (count == CW'(1)) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Pointers, occupancy, flags and read strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            wrap_q    <= 1'b0;
            overflow  <= 1'b0;
            rd_valid  <= 1'b0;
            full      <= 1'b0;
            empty     <= 1'b1;
            capturing <= 1'b0;
        end else begin
            count     <= count_d;
            full      <= (count_d == FULL_COUNT);
            empty     <= (count_d == '0);
            capturing <= (state_d == ST_CAPTURE);
            rd_valid  <= do_read;
            if (do_clear) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                overflow <= 1'b0;
                wrap_q   <= wrap;
            end else begin
                if (do_write) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (do_overwrite || do_read) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                if (do_overwrite) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

`ifdef ALU_TRACE_MISR_EN
    logic misr_fb;

    assign misr_fb = sig[W-1-MISR_TAP_TOP_0] ^ sig[W-1-MISR_TAP_TOP_1]
                   ^ sig[W-1-MISR_TAP_TOP_2] ^ sig[MISR_TAP_LOW];

    // MISR folds each captured result into the running signature
    always_ff @(posedge clk) begin
        if (rst || do_clear) begin
            sig <= '0;
        end else if (do_write) begin
            sig <= {sig[W-2:0], misr_fb} ^ cap_o;
        end
    end
`else
    assign sig = '0;
`endif

    trace_ram #(
        .DEPTH (DEPTH),
        .DW    (3*W+2)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (do_write),
        .waddr (wr_ptr),
        .wdata ({cap_s, cap_a, cap_b, cap_o}),
        .re    (do_read),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_alu_trace_buffer.sv
// tb/tb_alu_trace_buffer.sv - directed self-checking bench for alu_trace_buffer
module tb_alu_trace_buffer;

`ifdef ALU_TRACE_MISR_EN
    localparam bit MISR_ON = 1'b1;
`else
    localparam bit MISR_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cap_valid = 1'b0;
    logic [15:0] cap_a = '0;
    logic [15:0] cap_b = '0;
    logic [1:0]  cap_s = '0;
    logic [15:0] cap_o = '0;
    logic        arm = 1'b0;
    logic        stop = 1'b0;
    logic        wrap = 1'b0;
    logic        rd_req = 1'b0;
    logic        rd_valid;
    logic [49:0] rd_data;
    logic [3:0]  count;
    logic        full, empty, overflow, capturing;
    logic [15:0] sig;

    int passed = 0;
    int total  = 0;

    alu_trace_buffer #(.DEPTH(8), .W(16)) dut (
        .clk(clk), .rst(rst), .cap_valid(cap_valid), .cap_a(cap_a), .cap_b(cap_b),
        .cap_s(cap_s), .cap_o(cap_o), .arm(arm), .stop(stop), .wrap(wrap),
        .rd_req(rd_req), .rd_valid(rd_valid), .rd_data(rd_data), .count(count),
        .full(full), .empty(empty), .overflow(overflow), .capturing(capturing), .sig(sig)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cap(input logic [15:0] a, input logic [15:0] b,
                          input logic [1:0] s, input logic [15:0] o);
        cap_valid = 1'b1; cap_a = a; cap_b = b; cap_s = s; cap_o = o;
        step();
        cap_valid = 1'b0;
    endtask

    task automatic do_arm(input logic w);
        arm = 1'b1; wrap = w;
        step();
        arm = 1'b0; wrap = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        total++; if (count !== 4'd0) $display("FAIL reset_count got %0d exp 0", count); else passed++;
        total++; if (empty !== 1'b1 || full !== 1'b0) $display("FAIL reset_flags got empty=%0b full=%0b exp 1 0", empty, full); else passed++;
        total++; if (rd_valid !== 1'b0 || rd_data !== 50'd0) $display("FAIL reset_rd got v=%0b d=%0h exp 0 0", rd_valid, rd_data); else passed++;
        total++; if (overflow !== 1'b0 || capturing !== 1'b0 || sig !== 16'd0) $display("FAIL reset_misc got ov=%0b cap=%0b sig=%0h exp 0 0 0", overflow, capturing, sig); else passed++;
    endtask

    task automatic test_basic();
        logic [49:0] exp_d;
        do_arm(1'b0);
        total++; if (capturing !== 1'b1) $display("FAIL basic_arm got capturing=%0b exp 1", capturing); else passed++;
        do_cap(16'd3, 16'd2, 2'd0, 16'd5);
        total++; if (count !== 4'd1) $display("FAIL basic_latency got %0d exp 1", count); else passed++;
        do_cap(16'd3, 16'd2, 2'd1, 16'd1);
        do_stop();
        total++; if (count !== 4'd2 || capturing !== 1'b0) $display("FAIL basic_hold got count=%0d cap=%0b exp 2 0", count, capturing); else passed++;
        rd_req = 1'b1; step(); rd_req = 1'b0;
        exp_d = {2'd0, 16'd3, 16'd2, 16'd5};
        total++; if (rd_valid !== 1'b1 || rd_data !== exp_d) $display("FAIL basic_rd0 got v=%0b d=%0h exp 1 %0h", rd_valid, rd_data, exp_d); else passed++;
        step();
        total++; if (rd_valid !== 1'b0) $display("FAIL basic_pulse got %0b exp 0", rd_valid); else passed++;
        rd_req = 1'b1; step(); rd_req = 1'b0;
        exp_d = {2'd1, 16'd3, 16'd2, 16'd1};
        total++; if (rd_valid !== 1'b1 || rd_data !== exp_d) $display("FAIL basic_rd1 got v=%0b d=%0h exp 1 %0h", rd_valid, rd_data, exp_d); else passed++;
        total++; if (empty !== 1'b1 || count !== 4'd0 || capturing !== 1'b0) $display("FAIL basic_idle got empty=%0b count=%0d cap=%0b exp 1 0 0", empty, count, capturing); else passed++;
        do_stop();
        total++; if (capturing !== 1'b0) $display("FAIL idle_stop got capturing=%0b exp 0", capturing); else passed++;
    endtask

    task automatic test_no_wrap();
        do_arm(1'b0);
        for (int i = 1; i <= 8; i++) do_cap(16'(i), 16'(i + 1), 2'd2, 16'(i));
        total++; if (capturing !== 1'b0 || full !== 1'b1) $display("FAIL nowrap_hold got cap=%0b full=%0b exp 0 1", capturing, full); else passed++;
        do_cap(16'd9, 16'd9, 2'd2, 16'd9);
        total++; if (count !== 4'd8 || overflow !== 1'b0) $display("FAIL nowrap_ninth got count=%0d ov=%0b exp 8 0", count, overflow); else passed++;
        rd_req = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            total++;
            if (rd_valid !== 1'b1 || rd_data[15:0] !== 16'(i) || rd_data[31:16] !== 16'(i + 1))
                $display("FAIL nowrap_rd%0d got v=%0b d=%0h exp o=%0d", i, rd_valid, rd_data, i);
            else passed++;
        end
        rd_req = 1'b0;
        total++; if (empty !== 1'b1 || capturing !== 1'b0) $display("FAIL nowrap_empty got empty=%0b cap=%0b exp 1 0", empty, capturing); else passed++;
    endtask

    task automatic test_wrap();
        do_arm(1'b1);
        for (int i = 1; i <= 10; i++) do_cap(16'd0, 16'd0, 2'd3, 16'(i));
        total++; if (count !== 4'd8 || overflow !== 1'b1 || full !== 1'b1) $display("FAIL wrap_state got count=%0d ov=%0b full=%0b exp 8 1 1", count, overflow, full); else passed++;
        total++; if (capturing !== 1'b1) $display("FAIL wrap_capturing got %0b exp 1", capturing); else passed++;
        do_stop();
        rd_req = 1'b1;
        for (int i = 3; i <= 10; i++) begin
            step();
            total++;
            if (rd_valid !== 1'b1 || rd_data[15:0] !== 16'(i)) $display("FAIL wrap_rd%0d got v=%0b o=%0d exp 1 %0d", i, rd_valid, rd_data[15:0], i);
            else passed++;
        end
        rd_req = 1'b0;
        total++; if (empty !== 1'b1) $display("FAIL wrap_empty got %0b exp 1", empty); else passed++;
    endtask

    task automatic test_misr();
        do_arm(1'b0);
        do_cap(16'd0, 16'd0, 2'd0, 16'h0001);
        total++; if (sig !== (MISR_ON ? 16'h0001 : 16'h0000)) $display("FAIL misr_first got %0h exp %0h", sig, MISR_ON ? 16'h0001 : 16'h0000); else passed++;
        do_cap(16'd0, 16'd0, 2'd0, 16'h0002);
        total++; if (sig !== 16'h0000) $display("FAIL misr_second got %0h exp 0", sig); else passed++;
        do_cap(16'd0, 16'd0, 2'd0, 16'h8000);
        total++; if (sig !== (MISR_ON ? 16'h8000 : 16'h0000)) $display("FAIL misr_msb got %0h exp %0h", sig, MISR_ON ? 16'h8000 : 16'h0000); else passed++;
        do_cap(16'd0, 16'd0, 2'd0, 16'h0000);
        total++; if (sig !== (MISR_ON ? 16'h0001 : 16'h0000)) $display("FAIL misr_tap got %0h exp %0h", sig, MISR_ON ? 16'h0001 : 16'h0000); else passed++;
        do_stop();
        do_arm(1'b0);
        total++; if (sig !== 16'h0000 || count !== 4'd0) $display("FAIL misr_clear got sig=%0h count=%0d exp 0 0", sig, count); else passed++;
        do_stop();
    endtask

    task automatic test_arm_priority();
        do_arm(1'b0);
        do_cap(16'd1, 16'd1, 2'd0, 16'd2);
        do_cap(16'd2, 16'd2, 2'd0, 16'd4);
        do_cap(16'd3, 16'd3, 2'd0, 16'd6);
        do_stop();
        total++; if (count !== 4'd3) $display("FAIL prio_count got %0d exp 3", count); else passed++;
        rd_req = 1'b1; arm = 1'b1;
        step();
        rd_req = 1'b0; arm = 1'b0;
        total++; if (rd_valid !== 1'b0 || count !== 4'd0 || capturing !== 1'b1) $display("FAIL prio_arm got v=%0b count=%0d cap=%0b exp 0 0 1", rd_valid, count, capturing); else passed++;
        do_stop();
        rd_req = 1'b1; step(); rd_req = 1'b0;
        total++; if (rd_valid !== 1'b0 || count !== 4'd0 || empty !== 1'b1) $display("FAIL prio_empty_rd got v=%0b count=%0d empty=%0b exp 0 0 1", rd_valid, count, empty); else passed++;
    endtask

    task automatic test_reset_mid();
        do_arm(1'b0);
        for (int i = 1; i <= 4; i++) do_cap(16'd7, 16'd7, 2'd1, 16'(i * 3));
        total++; if (count !== 4'd4) $display("FAIL rstmid_pre got %0d exp 4", count); else passed++;
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++; if (count !== 4'd0 || empty !== 1'b1 || capturing !== 1'b0 || sig !== 16'd0) $display("FAIL rstmid got count=%0d empty=%0b cap=%0b sig=%0h exp 0 1 0 0", count, empty, capturing, sig); else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_no_wrap();
        test_wrap();
        test_misr();
        test_arm_priority();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/alu_trace_buffer.md
# alu_trace_buffer

Observation-side companion to the processor's ALU: captures every executed ALU operation (operands, select, result) into a circular trace buffer and drains it through a request/valid read port. It sits inside `TOP` beside the ALU, turning the stimulus applied by the top-level bench into a readable record. An optional 16-bit MISR signature over results allows single-compare regression checks.

## Interface

- Parameters:
- `DEPTH`, 8: entries; power of two, at least 2.
- `W`, 16: operand/result width.
- Ports (the only clock is `clk`; reset is synchronous and active-high, named `rst`):
- `clk` in 1: clock.
- `rst` in 1: synchronous active-high reset.
- `cap_valid` in 1: ALU operation completes this cycle.
- `cap_a` in W: ALU operand A.
- `cap_b` in W: ALU operand B.
- `cap_s` in 2: ALU select.
- `cap_o` in W: ALU result.
- `arm` in 1: clear the buffer and start capture.
- `stop` in 1: end capture.
- `wrap` in 1: 1 = overwrite oldest entry when full; 0 = stop when full. Sampled on `arm`.
- `rd_req` in 1: request the oldest entry.
- `rd_valid` out 1: `rd_data` valid, single-cycle pulse.
- `rd_data` out 3W+2: {s, a, b, o}.
- `count` out log2(DEPTH)+1: entries held.
- `full` out 1: `count == DEPTH`.
- `empty` out 1: `count == 0`.
- `overflow` out 1: sticky; an entry was overwritten.
- `capturing` out 1: state is CAPTURE.
- `sig` out W: MISR signature.

## Operation

- States: IDLE, CAPTURE, HOLD.
- IDLE → CAPTURE on `arm`. This also clears the pointers, `count`, `overflow` and `sig`, and latches `wrap`.
- CAPTURE: each `cap_valid` writes an entry at the write pointer, which then increments mod DEPTH.
  - Full with latched wrap=0: the write completes, then the state goes to HOLD. `cap_valid` is never dropped before the buffer is full.
  - Full with wrap=1: the new entry overwrites the oldest, the read pointer advances, `count` stays at DEPTH, and `overflow` sets.
- CAPTURE → HOLD on `stop`. A `cap_valid` in the same cycle is still captured.
- `arm` during CAPTURE is ignored.
- HOLD: `rd_req` with `!empty` returns the oldest entry, advances the read pointer and decrements `count`.
  - `rd_req` while empty is ignored: no `rd_valid`, no state change.
  - `cap_valid` is ignored.
- HOLD → IDLE when the last entry is read.
- HOLD → CAPTURE on `arm`, which re-clears as from IDLE. `arm` has priority over `rd_req` in the same cycle; that read is discarded.
- `stop` in IDLE or HOLD has no effect.
- MISR, updated on each captured entry:
  - fb = sig[15]^sig[14]^sig[12]^sig[3].
  - sig ← {sig[14:0], fb} ^ cap_o.
  - For W≠16, the taps are applied to the top/low bits identically.

## Timing

- Reset values: state IDLE; `rd_valid` 0; `rd_data` 0; `count` 0; `full` 0; `empty` 1; `overflow` 0; `capturing` 0; `sig` 0.
- `rst` mid-capture or mid-drain discards all entries the next edge.
- Capture latency: an entry is visible in `count` one cycle after `cap_valid`.
- Read latency: 1 cycle. `rd_req` at edge N gives `rd_valid` and `rd_data` registered after edge N, valid for one cycle.
- Back-to-back `rd_req` returns one entry per cycle.
- `full`, `empty` and `capturing` are registered and track `count` and state in the same cycle.

## Configuration

- `ALU_TRACE_MISR_EN`:
  - Defined: the MISR is implemented as above.
  - Undefined: no MISR register; `sig` is tied to 0. All other behaviour is identical.

## Structure

- Shared package `alu_trace_pkg`:
  - State enum (IDLE/CAPTURE/HOLD).
  - Entry typedef {s, a, b, o}.
  - MISR tap constants.
- Storage is one sub-module, `trace_ram`: DEPTH×(3W+2), one write port, registered read port.
- Control, pointers and MISR live in the top.

## Test plan

- Reset, then `arm` wrap=0 and capture (a, b, s, o) = (3, 2, 0, 5) and (3, 2, 1, 1), then `stop`. Expect `count`=2. `rd_req`×2 returns those entries in order, then the state is IDLE and `empty`=1.
- wrap=0 with 9 captures of o=1..9 (DEPTH 8). Expect HOLD after the 8th, 9th ignored, `overflow`=0, reads return o=1..8.
- wrap=1 with 10 captures of o=1..10 and no `stop`. Expect `count`=8, `overflow`=1; after `stop`, reads return o=3..10.
- With `ALU_TRACE_MISR_EN`, capture o=0x0001 then o=0x0002. Expect `sig`=0x0001 after the first and 0x0000 after the second. Without the macro, `sig`=0 throughout.
- HOLD with 3 entries: `rd_req` and `arm` in the same cycle. Expect no `rd_valid`, `count`=0, state CAPTURE. Then `rd_req` while empty: no `rd_valid`.
- `rst` asserted after 4 captures. Expect `count`=0, `empty`=1, `capturing`=0, `sig`=0 on the next edge.
